hms_counter: RTL
================

HMS_COUNTER -- requirements
Module: hms_counter

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency in Hz.
REQ-002 Parameter BLINK_HZ, default 2, blink rate for digits under edit.
REQ-003 clk  input  1  system clock; all logic on rising edge; one clock domain.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 tick_1hz  input  1  one-cycle enable pulse, once per second.
REQ-006 key_mode_p  input  1  one-cycle pulse from debounced mode key.
REQ-007 key_inc_p  input  1  one-cycle pulse from debounced increment key.
REQ-008 sec_ones 4, sec_tens 3, min_ones 4, min_tens 3, hr_ones 4, hr_tens 2  outputs  BCD time digits, registered.
REQ-009 mode  output  2  current state: 0 RUN, 1 SET_H, 2 SET_M.
REQ-010 blink_mask  output  6  per-digit blank request; bit0 sec_ones through bit5 hr_tens; 1 = blank.
REQ-011 day_p  output  1  one-cycle pulse on 23:59:59 -> 00:00:00 rollover.

Function
REQ-012 FSM states SHALL be RUN, SET_H, SET_M; key_mode_p SHALL advance RUN->SET_H->SET_M->RUN.
REQ-013 In RUN, tick_1hz SHALL increment time by one second, visible on outputs in the cycle after the tick.
REQ-014 Carry chain: sec_ones 9->0 increments sec_tens; sec_tens 5->0 increments min_ones; min 59->00 increments hours; hours 23->00.
REQ-015 hr_ones SHALL wrap 9->0 with hr_tens increment, except at 23, which wraps to 00.
REQ-016 day_p SHALL assert for exactly one cycle, coincident with outputs showing 00:00:00 after a rollover.
REQ-017 In RUN, key_inc_p SHALL be ignored.
REQ-018 In SET_H and SET_M, tick_1hz SHALL be ignored; time is frozen.
REQ-019 In SET_H, key_inc_p SHALL increment hours modulo 24, no effect on minutes/seconds, no day_p.
REQ-020 In SET_M, key_inc_p SHALL increment minutes modulo 60, no carry into hours.
REQ-021 On the SET_M->RUN transition, seconds SHALL be cleared to 00.
REQ-022 Simultaneous key_mode_p and key_inc_p SHALL apply the mode change only; the inc pulse is dropped.
REQ-023 Simultaneous tick_1hz and key_mode_p in RUN SHALL apply both: time increments and state moves to SET_H.
REQ-024 Blink phase SHALL toggle every CLK_HZ/(2*BLINK_HZ) cycles; the phase counter SHALL restart at 0 with phase visible (0) on every mode change.
REQ-025 blink_mask SHALL be 6'b110000 in SET_H and 6'b001100 in SET_M when phase=1, else 0; always 0 in RUN.
REQ-026 A key_inc_p in a set mode SHALL restart the blink counter with phase 0, so the edited digit is shown immediately.
REQ-027 All outputs SHALL be driven from registers; no combinational path from inputs to outputs.

Reset
REQ-028 While rst=1 at a clock edge: all digits 0, mode RUN, blink_mask 0, phase 0, blink counter 0, day_p 0.
REQ-029 Reset asserted mid-edit or mid-carry SHALL take priority over all other inputs in the same cycle.

Structure
REQ-030 Package hms_pkg SHALL hold the mode encoding (RUN/SET_H/SET_M) and digit limits (9, 5, 23).
REQ-031 Sub-module blink_gen (parameters CLK_HZ, BLINK_HZ; inputs clk, rst, restart; output phase) SHALL implement the blink timer.
REQ-032 Total RTL is 120-400 lines; the counter chain and FSM live in hms_counter.

Verification
REQ-033 Preload 23:59:58 via set mode, two ticks in RUN -> 23:59:59, then 00:00:00 with day_p high one cycle.
REQ-034 From 00:00:00, mode, 25 inc pulses -> hours 01, minutes 00, no day_p; mode, mode -> RUN with seconds 00.
REQ-035 In SET_M at 12:59, one inc -> 12:00 (no hour carry); tick_1hz during SET_M -> no change.
REQ-036 key_mode_p and key_inc_p together in SET_H at 05 -> mode SET_M, hours stay 05.
REQ-037 With CLK_HZ=8, BLINK_HZ=2: in SET_H, blink_mask 000000 for 2 cycles, then 110000 for 2, repeating; inc pulse restarts with 000000.
REQ-038 rst asserted during SET_M at 10:30:15 -> next cycle 00:00:00, mode RUN, blink_mask 0.

Source files
------------

// File: rtl/hms_pkg.sv
// hms_pkg: mode encoding, BCD digit limits and mode sequencing shared by the clock
package hms_pkg;
   typedef enum logic [1:0] {RUN = 2'd0, SET_H = 2'd1, SET_M = 2'd2} mode_t;
   localparam logic [3:0] ONES_MAX    = 4'd9;
   localparam logic [2:0] TENS_MAX    = 3'd5;
   localparam logic [1:0] HR_TENS_MAX = 2'd2;
   localparam logic [3:0] HR_ONES_MAX = 4'd3;
   function automatic mode_t next_mode(input mode_t m);
      return m == RUN ? SET_H : m == SET_H ? SET_M : RUN;
   endfunction
endpackage

// File: rtl/blink_gen.sv
// blink_gen: half-period blink phase timer, restartable to the visible (0) phase
module blink_gen #(
   parameter int CLK_HZ   = 50_000_000,
   parameter int BLINK_HZ = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic phase
);
   localparam int HALF = CLK_HZ / (2 * BLINK_HZ);
   localparam int W = HALF > 1 ? $clog2(HALF) : 1;
   localparam logic [W-1:0] LAST = W'(HALF - 1);
   logic [W-1:0] cnt;
   always_ff @(posedge clk) begin
      if (rst || restart) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (cnt == LAST) begin
         cnt   <= '0;
         phase <= ~phase;
      end else begin
         cnt <= cnt + W'(1);
      end
   end
endmodule

// File: rtl/hms_counter.sv
// hms_counter: BCD hh:mm:ss clock with RUN / SET_H / SET_M editing and digit blink
module hms_counter
   import hms_pkg::*;
#(
   parameter int CLK_HZ   = 50_000_000,
   parameter int BLINK_HZ = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1hz,
   input  logic       key_mode_p,
   input  logic       key_inc_p,
   output logic [3:0] sec_ones,
   output logic [2:0] sec_tens,
   output logic [3:0] min_ones,
   output logic [2:0] min_tens,
   output logic [3:0] hr_ones,
   output logic [1:0] hr_tens,
   output logic [1:0] mode,
   output logic [5:0] blink_mask,
   output logic       day_p
);
   mode_t      mode_q;
   logic       phase, restart, run_tick, day_w;
   logic       s1_w, s10_w, m1_w, m10_w, h_wrap;
   logic [3:0] sec_ones_t, min_ones_t, min_ones_i, hr_ones_i;
   logic [2:0] sec_tens_t, min_tens_t, min_tens_i;
   logic [1:0] hr_tens_i;
   always_comb begin
      run_tick   = mode_q == RUN && tick_1hz;
      restart    = key_mode_p || (key_inc_p && mode_q != RUN);
      s1_w       = sec_ones == ONES_MAX;
      s10_w      = s1_w && sec_tens == TENS_MAX;
      m1_w       = s10_w && min_ones == ONES_MAX;
      m10_w      = m1_w && min_tens == TENS_MAX;
      h_wrap     = hr_tens == HR_TENS_MAX && hr_ones == HR_ONES_MAX;
      day_w      = m10_w && h_wrap;
      sec_ones_t = s1_w ? 4'd0 : sec_ones + 4'd1;
      sec_tens_t = s10_w ? 3'd0 : s1_w ? sec_tens + 3'd1 : sec_tens;
      min_ones_i = min_ones == ONES_MAX ? 4'd0 : min_ones + 4'd1;
      min_tens_i = min_ones != ONES_MAX ? min_tens : min_tens == TENS_MAX ? 3'd0 : min_tens + 3'd1;
      min_ones_t = s10_w ? min_ones_i : min_ones;
      min_tens_t = s10_w ? min_tens_i : min_tens;
      hr_ones_i  = (h_wrap || hr_ones == ONES_MAX) ? 4'd0 : hr_ones + 4'd1;
      hr_tens_i  = h_wrap ? 2'd0 : hr_ones == ONES_MAX ? hr_tens + 2'd1 : hr_tens;
   end
   // Mode change wins over inc; a RUN tick still lands alongside a mode change.
   always_ff @(posedge clk) begin
      if (rst) begin
         {sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens} <= '0;
         mode_q <= RUN;
         day_p  <= 1'b0;
      end else begin
         day_p <= run_tick && day_w;
         if (run_tick) begin
            sec_ones <= sec_ones_t;
            sec_tens <= sec_tens_t;
            min_ones <= min_ones_t;
            min_tens <= min_tens_t;
            if (m10_w) begin
               hr_ones <= hr_ones_i;
               hr_tens <= hr_tens_i;
            end
         end
         if (key_mode_p) begin
            mode_q <= next_mode(mode_q);
            if (mode_q == SET_M) begin
               sec_ones <= 4'd0;
               sec_tens <= 3'd0;
            end
         end else if (key_inc_p && mode_q == SET_H) begin
            hr_ones <= hr_ones_i;
            hr_tens <= hr_tens_i;
         end else if (key_inc_p && mode_q == SET_M) begin
            min_ones <= min_ones_i;
            min_tens <= min_tens_i;
         end
      end
   end
   blink_gen #(.CLK_HZ(CLK_HZ), .BLINK_HZ(BLINK_HZ)) u_blink (
      .clk(clk), .rst(rst), .restart(restart), .phase(phase)
   );
   assign mode       = mode_q;
   assign blink_mask = !phase ? 6'b000000 : mode_q == SET_H ? 6'b110000 : mode_q == SET_M ? 6'b001100 : 6'b000000;
endmodule
